// File: rtl/spi_master_ctrl_if.sv
// Command/response bus between a command source and the SPI master.
// master modport: command source side; slave modport: the SPI master block.
interface spi_master_ctrl_if #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_CS_NUM     = 4
);
  logic                      tx_valid;
  logic [P_DATA_WIDTH-1:0]   tx_data;
  logic [$clog2(P_CS_NUM):0] cs_sel;
  logic                      cpol;
  logic                      cpha;
  logic                      lsb_first;
  logic                      tx_ready;
  logic                      rx_valid;
  logic [P_DATA_WIDTH-1:0]   rx_data;
  logic                      busy;

  modport master (
    output tx_valid, tx_data, cs_sel, cpol, cpha, lsb_first,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data, cs_sel, cpol, cpha, lsb_first,
    output tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Full-duplex SPI master: 4 CPOL/CPHA modes, MSB/LSB order, multiple chip selects.
// Latency: handshake to rx_valid = P_CLK_DIV*(2*P_DATA_WIDTH+2) clk_100 cycles.
// Backpressure: tx_ready low while a transfer or CS gap runs; commands offered then are dropped.
module spi_master_ctrl #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_CS_NUM     = 4,
  parameter int P_CLK_DIV    = 4,
  parameter int P_CS_POLAR   = 0
) (
  input  logic                clk_100,
  input  logic                a_rst,
  input  logic                s_rst,
  spi_master_ctrl_if.slave    cmd,
  output logic                SCK,
  output logic [P_CS_NUM-1:0] CS,
  output logic                MOSI,
  input  logic                MISO
);
  localparam int W   = P_DATA_WIDTH;
  localparam int CSW = $clog2(P_CS_NUM) + 1;
  localparam int DW  = $clog2(P_CLK_DIV) + 1;
  localparam int EW  = $clog2(2 * P_DATA_WIDTH) + 1;

  localparam logic                CS_ACT   = (P_CS_POLAR != 0);
  localparam logic [P_CS_NUM-1:0] CS_IDLE  = {P_CS_NUM{~CS_ACT}};
  localparam logic [DW-1:0]       DIV_LAST = DW'(P_CLK_DIV - 1);
  localparam logic [EW-1:0]       EDGES    = EW'(2 * P_DATA_WIDTH);
  localparam logic [EW-1:0]       EDGE_PEN = EW'(2 * P_DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                state_q, state_n;
  logic [DW-1:0]         div_q, div_n;
  logic [EW-1:0]         edge_q, edge_n;
  logic [W-1:0]          tx_sh_q, tx_sh_n;
  logic [W-1:0]          rx_sh_q, rx_sh_n;
  logic                  cpol_q, cpol_n;
  logic                  cpha_q, cpha_n;
  logic                  lsb_q, lsb_n;
  logic                  sck_q, sck_n;
  logic [P_CS_NUM-1:0]   cs_q, cs_n;
  logic                  mosi_q, mosi_n;
  logic                  ready_q, ready_n;
  logic                  busy_q, busy_n;
  logic                  rxv_q, rxv_n;
  logic [W-1:0]          rxd_q, rxd_n;

  logic tick, start, drive, sample;

  assign SCK          = sck_q;
  assign CS           = cs_q;
  assign MOSI         = mosi_q;
  assign cmd.tx_ready = ready_q;
  assign cmd.busy     = busy_q;
  assign cmd.rx_valid = rxv_q;
  assign cmd.rx_data  = rxd_q;

  // State and datapath registers; everything visible outside comes straight from here.
  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sck_q   <= 1'b0;
      cs_q    <= CS_IDLE;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      rxv_q   <= 1'b0;
      rxd_q   <= '0;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      edge_q  <= edge_n;
      tx_sh_q <= tx_sh_n;
      rx_sh_q <= rx_sh_n;
      cpol_q  <= cpol_n;
      cpha_q  <= cpha_n;
      lsb_q   <= lsb_n;
      sck_q   <= sck_n;
      cs_q    <= cs_n;
      mosi_q  <= mosi_n;
      ready_q <= ready_n;
      busy_q  <= busy_n;
      rxv_q   <= rxv_n;
      rxd_q   <= rxd_n;
    end
  end

  // Next-state logic: phase timer, SCK edge sequencing, shift/sample and command accept.
  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    edge_n  = edge_q;
    tx_sh_n = tx_sh_q;
    rx_sh_n = rx_sh_q;
    cpol_n  = cpol_q;
    cpha_n  = cpha_q;
    lsb_n   = lsb_q;
    sck_n   = sck_q;
    cs_n    = cs_q;
    mosi_n  = mosi_q;
    ready_n = ready_q;
    busy_n  = busy_q;
    rxv_n   = 1'b0;
    rxd_n   = rxd_q;
    drive   = 1'b0;
    sample  = 1'b0;
    tick    = (div_q == DIV_LAST);
    // tx_ready is only high in IDLE or the last GAP cycle, so this is the handshake
    start   = cmd.tx_valid && ready_q && (state_q == IDLE || state_q == GAP);

    case (state_q)
      IDLE: ;
      SETUP: begin
        div_n = div_q + DW'(1);
        if (tick) begin
          // first leading edge
          div_n   = '0;
          sck_n   = ~sck_q;
          edge_n  = EW'(1);
          state_n = SHIFT;
          if (cpha_q) drive = 1'b1;
          else        sample = 1'b1;
        end
      end
      SHIFT: begin
        div_n = div_q + DW'(1);
        if (tick) begin
          div_n = '0;
          if (edge_q == EDGES) begin
            // SCK has rested at cpol for one half-period after the final edge
            state_n = HOLD;
          end else begin
            sck_n  = ~sck_q;
            edge_n = edge_q + EW'(1);
            // edge being produced is edge_q+1: odd numbers are leading edges
            if (!edge_q[0]) begin
              if (cpha_q) drive = 1'b1;
              else        sample = 1'b1;
            end else begin
              if (cpha_q)                 sample = 1'b1;
              else if (edge_q != EDGE_PEN) drive = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        div_n = div_q + DW'(1);
        if (tick) begin
          div_n   = '0;
          cs_n    = CS_IDLE;
          mosi_n  = 1'b0;
          rxd_n   = rx_sh_q;
          rxv_n   = 1'b1;
          state_n = GAP;
          if (P_CLK_DIV == 1) begin
            ready_n = 1'b1;
            busy_n  = 1'b0;
          end
        end
      end
      GAP: begin
        div_n = div_q + DW'(1);
        // open tx_ready one cycle early so a handshake lands exactly at gap end
        if (P_CLK_DIV > 1 && div_q == DW'(P_CLK_DIV - 2)) begin
          ready_n = 1'b1;
          busy_n  = 1'b0;
        end
        if (tick) begin
          div_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (drive) begin
      mosi_n  = lsb_q ? tx_sh_q[0] : tx_sh_q[W-1];
      tx_sh_n = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    end
    if (sample) begin
      rx_sh_n = lsb_q ? {MISO, rx_sh_q[W-1:1]} : {rx_sh_q[W-2:0], MISO};
    end

    if (start) begin
      tx_sh_n = cmd.tx_data;
      rx_sh_n = '0;
      cpol_n  = cmd.cpol;
      cpha_n  = cmd.cpha;
      lsb_n   = cmd.lsb_first;
      sck_n   = cmd.cpol;
      cs_n    = CS_IDLE;
      for (int i = 0; i < P_CS_NUM; i++) begin
        if (cmd.cs_sel == CSW'(i)) cs_n[i] = CS_ACT;
      end
      ready_n = 1'b0;
      busy_n  = 1'b1;
      div_n   = '0;
      edge_n  = '0;
      state_n = SETUP;
      if (!cmd.cpha) begin
        mosi_n  = cmd.lsb_first ? cmd.tx_data[0] : cmd.tx_data[W-1];
        tx_sh_n = cmd.lsb_first ? (cmd.tx_data >> 1) : (cmd.tx_data << 1);
      end
    end

    if (s_rst) begin
      state_n = IDLE;
      div_n   = '0;
      edge_n  = '0;
      tx_sh_n = '0;
      rx_sh_n = '0;
      cpol_n  = 1'b0;
      cpha_n  = 1'b0;
      lsb_n   = 1'b0;
      sck_n   = 1'b0;
      cs_n    = CS_IDLE;
      mosi_n  = 1'b0;
      ready_n = 1'b1;
      busy_n  = 1'b0;
      rxv_n   = 1'b0;
      rxd_n   = '0;
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: scoreboard of expected rx words plus
// timing checks on CS, SCK and MOSI for two parameter sets.
module tb_spi_master_ctrl;
  logic clk_100 = 1'b0;
  logic a_rst;
  logic s_rst;
  always #5 clk_100 = ~clk_100;

  int cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // DUT0: W=8, 4 CS, DIV=2, active-low CS
  spi_master_ctrl_if #(.P_DATA_WIDTH(8), .P_CS_NUM(4)) if0 ();
  logic       sck0, mosi0, miso0;
  logic [3:0] cs0;
  logic [1:0] miso_mode;
  assign miso0 = (miso_mode == 2'd0) ? mosi0 : miso_mode[0];

  spi_master_ctrl #(.P_DATA_WIDTH(8), .P_CS_NUM(4), .P_CLK_DIV(2), .P_CS_POLAR(0)) dut0 (
    .clk_100(clk_100), .a_rst(a_rst), .s_rst(s_rst), .cmd(if0),
    .SCK(sck0), .CS(cs0), .MOSI(mosi0), .MISO(miso0)
  );

  // DUT1: W=16, DIV=1, loopback
  spi_master_ctrl_if #(.P_DATA_WIDTH(16), .P_CS_NUM(4)) if1 ();
  logic       sck1, mosi1;
  logic [3:0] cs1;

  spi_master_ctrl #(.P_DATA_WIDTH(16), .P_CS_NUM(4), .P_CLK_DIV(1), .P_CS_POLAR(0)) dut1 (
    .clk_100(clk_100), .a_rst(a_rst), .s_rst(s_rst), .cmd(if1),
    .SCK(sck1), .CS(cs1), .MOSI(mosi1), .MISO(mosi1)
  );

  logic [7:0]  q0[$];
  logic [15:0] q1[$];

  always @(negedge clk_100) begin
    if (if0.rx_valid === 1'b1) begin
      check_val("rx0_pending", (q0.size() != 0), 1);
      if (q0.size() != 0) check_val("rx0_data", if0.rx_data, q0.pop_front());
    end
    if (if1.rx_valid === 1'b1) begin
      check_val("rx1_pending", (q1.size() != 0), 1);
      if (q1.size() != 0) check_val("rx1_data", if1.rx_data, q1.pop_front());
    end
  end

  task automatic wait_ready0();
    int n;
    n = 0;
    @(negedge clk_100);
    while (if0.tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk_100);
      n++;
    end
    check_val("ready0_wait", if0.tx_ready, 1);
  endtask

  task automatic drive0(input logic [7:0] d, input logic [2:0] sel,
                        input logic pol, input logic pha, input logic lsb);
    if0.tx_valid  = 1'b1;
    if0.tx_data   = d;
    if0.cs_sel    = sel;
    if0.cpol      = pol;
    if0.cpha      = pha;
    if0.lsb_first = lsb;
  endtask

  // One full DUT0 transfer with timing, CS, SCK and MOSI-order checks.
  task automatic xfer0(input string tag, input logic [7:0] d, input logic [2:0] sel,
                       input logic pol, input logic pha, input logic lsb,
                       input logic [1:0] mm, input logic [7:0] exp_rx);
    int lat, leads, cs_cyc, h;
    logic [7:0] seq, exp_seq;
    logic [3:0] exp_cs;
    logic prev;
    lat = -1; leads = 0; cs_cyc = 0; seq = '0;
    for (int i = 0; i < 8; i++) exp_seq[7-i] = lsb ? d[i] : d[7-i];
    exp_cs = 4'hF;
    if (sel < 3'd4) exp_cs[sel[1:0]] = 1'b0;
    miso_mode = mm;
    wait_ready0();
    drive0(d, sel, pol, pha, lsb);
    q0.push_back(exp_rx);
    @(negedge clk_100);
    if0.tx_valid = 1'b0;
    h = cyc;
    check_val({tag, "_ready_low"}, if0.tx_ready, 0);
    check_val({tag, "_busy"}, if0.busy, 1);
    check_val({tag, "_sck_idle"}, sck0, pol);
    check_val({tag, "_cs_sel"}, cs0, exp_cs);
    prev = sck0;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      if (cs0 != 4'hF) cs_cyc++;
      if (sck0 != prev) begin
        if ((sck0 != pol) != pha) seq = {seq[6:0], mosi0};
        if (sck0 != pol) leads++;
      end
      prev = sck0;
      if (if0.rx_valid) lat = cyc - h;
      @(negedge clk_100);
    end
    check_val({tag, "_latency"}, lat, 36);
    check_val({tag, "_cs_cycles"}, cs_cyc, (sel < 3'd4) ? 36 : 0);
    check_val({tag, "_lead_edges"}, leads, 8);
    check_val({tag, "_mosi_seq"}, seq, exp_seq);
    check_val({tag, "_sck_rest"}, sck0, pol);
    check_val({tag, "_cs_release"}, cs0, 4'hF);
  endtask

  logic prev_sck;
  int   toggles, nrx, gap, t_rx0, t_rx1, h1, lat1;
  logic gap_done;

  initial begin
    a_rst = 1'b1;
    s_rst = 1'b0;
    miso_mode = 2'd0;
    if0.tx_valid = 1'b0; if0.tx_data = '0; if0.cs_sel = '0;
    if0.cpol = 1'b0; if0.cpha = 1'b0; if0.lsb_first = 1'b0;
    if1.tx_valid = 1'b0; if1.tx_data = '0; if1.cs_sel = '0;
    if1.cpol = 1'b0; if1.cpha = 1'b0; if1.lsb_first = 1'b0;
    repeat (3) @(negedge clk_100);

    check_val("rst_tx_ready", if0.tx_ready, 1);
    check_val("rst_rx_valid", if0.rx_valid, 0);
    check_val("rst_rx_data", if0.rx_data, 0);
    check_val("rst_busy", if0.busy, 0);
    check_val("rst_sck", sck0, 0);
    check_val("rst_mosi", mosi0, 0);
    check_val("rst_cs", cs0, 4'hF);
    a_rst = 1'b0;

    // mode 0, MSB first, loopback
    xfer0("m0", 8'hA5, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'hA5);
    // mode 3, LSB first, MISO tied high
    xfer0("m3", 8'h01, 3'd2, 1'b1, 1'b1, 1'b1, 2'd1, 8'hFF);
    // mode 2, MSB first, MISO tied low
    xfer0("m2", 8'h96, 3'd3, 1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
    // out-of-range chip select: full timing, no CS
    xfer0("cs5", 8'h6E, 3'd5, 1'b0, 1'b0, 1'b1, 2'd0, 8'h6E);

    // back-to-back with tx_valid held high, mode 1
    miso_mode = 2'd0;
    wait_ready0();
    drive0(8'h3C, 3'd0, 1'b0, 1'b1, 1'b0);
    q0.push_back(8'h3C);
    q0.push_back(8'hC3);
    @(negedge clk_100);
    if0.tx_data = 8'hC3;
    nrx = 0; gap = 0; gap_done = 1'b0; t_rx0 = 0; t_rx1 = 0;
    for (int i = 0; i < 120 && nrx < 2; i++) begin
      @(negedge clk_100);
      if (if0.rx_valid) begin
        if (nrx == 0) t_rx0 = cyc;
        else          t_rx1 = cyc;
        nrx++;
      end
      if (nrx == 1 && !gap_done) begin
        if (cs0 == 4'hF) gap++;
        else begin
          gap_done = 1'b1;
          if0.tx_valid = 1'b0;
        end
      end
    end
    if0.tx_valid = 1'b0;
    check_val("b2b_rx_count", nrx, 2);
    check_val("b2b_cs_gap", gap, 2);
    check_val("b2b_rx_spacing", t_rx1 - t_rx0, 38);

    // command offered while busy must be dropped
    wait_ready0();
    drive0(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0);
    q0.push_back(8'h5A);
    @(negedge clk_100);
    if0.tx_valid = 1'b0;
    repeat (6) @(negedge clk_100);
    drive0(8'hFF, 3'd3, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk_100);
    if0.tx_valid = 1'b0;
    for (int i = 0; i < 100 && !if0.rx_valid; i++) @(negedge clk_100);
    repeat (10) @(negedge clk_100);
    check_val("drop_cs_idle", cs0, 4'hF);
    check_val("drop_busy", if0.busy, 0);
    check_val("drop_ready", if0.tx_ready, 1);

    // asynchronous reset at SCK edge 5
    wait_ready0();
    drive0(8'hA5, 3'd1, 1'b0, 1'b0, 1'b0);
    q0.push_back(8'hA5);
    @(negedge clk_100);
    if0.tx_valid = 1'b0;
    toggles = 0;
    prev_sck = sck0;
    for (int i = 0; i < 100 && toggles < 5; i++) begin
      @(negedge clk_100);
      if (sck0 != prev_sck) toggles++;
      prev_sck = sck0;
    end
    check_val("arst_edge5", toggles, 5);
    check_val("arst_cs_pre", cs0, 4'hD);
    #2 a_rst = 1'b1;
    #1;
    check_val("arst_cs", cs0, 4'hF);
    check_val("arst_sck", sck0, 0);
    check_val("arst_mosi", mosi0, 0);
    check_val("arst_ready", if0.tx_ready, 1);
    check_val("arst_rx_valid", if0.rx_valid, 0);
    q0.delete();
    @(negedge clk_100);
    a_rst = 1'b0;
    repeat (60) @(negedge clk_100);
    xfer0("post_arst", 8'h81, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h81);

    // synchronous reset mid-transfer
    wait_ready0();
    drive0(8'h33, 3'd2, 1'b0, 1'b0, 1'b0);
    q0.push_back(8'h33);
    @(negedge clk_100);
    if0.tx_valid = 1'b0;
    repeat (8) @(negedge clk_100);
    s_rst = 1'b1;
    #1;
    check_val("srst_before_edge", cs0, 4'hB);
    @(posedge clk_100);
    #1;
    check_val("srst_cs", cs0, 4'hF);
    check_val("srst_sck", sck0, 0);
    check_val("srst_ready", if0.tx_ready, 1);
    q0.delete();
    @(negedge clk_100);
    s_rst = 1'b0;
    repeat (60) @(negedge clk_100);

    // DUT1: DIV=1, W=16, mode 2, loopback
    if1.tx_valid = 1'b1; if1.tx_data = 16'hBEEF; if1.cs_sel = 3'd0;
    if1.cpol = 1'b1; if1.cpha = 1'b0; if1.lsb_first = 1'b0;
    check_val("d1_ready", if1.tx_ready, 1);
    q1.push_back(16'hBEEF);
    @(negedge clk_100);
    if1.tx_valid = 1'b0;
    h1 = cyc;
    lat1 = -1;
    check_val("d1_cs", cs1, 4'hE);
    for (int i = 0; i < 100 && lat1 < 0; i++) begin
      if (if1.rx_valid) lat1 = cyc - h1;
      @(negedge clk_100);
    end
    check_val("d1_latency", lat1, 34);
    check_val("d1_sck_rest", sck1, 1);
    repeat (3) @(negedge clk_100);

    check_val("q0_drained", q0.size(), 0);
    check_val("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
